parity_frame_checker: RTL and testbench

- Receiving end of the 3-bit even-parity generator path. Data bits and their parity bit arrive serially, one per valid cycle.
- The block deserialises each frame and recomputes parity over the data bits.
- It presents the parallel word with a one-cycle valid pulse and an error flag, and keeps a saturating count of parity failures.
- It sits between the serial link and the downstream consumer of the 3-bit words.

---
 rtl/parity_frame_checker_if.sv | 24 ++
 rtl/parity_frame_checker.sv | 89 ++++++++
 tb/tb_parity_frame_checker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_if.sv
// rtl/parity_frame_checker_if.sv - serial-in / parallel-out bundle for the parity frame checker.
interface parity_frame_checker_if #(
  parameter int DATA_W    = 3,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_start;
  logic                 in_bit;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic                 parity_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_start, in_bit,
    input  out_valid, out_data, parity_err, busy, err_count
  );

  modport slave (
    input  in_valid, in_start, in_bit,
    output out_valid, out_data, parity_err, busy, err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - deserialises MSB-first even-parity frames and flags parity failures.
module parity_frame_checker #(
  parameter int DATA_W    = 3,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic reset,
  parity_frame_checker_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t               state, state_next;
  logic [DATA_W-1:0]    shreg;
  logic [CNT_W-1:0]     cnt;
  logic                 xacc;
  logic                 ov_r;
  logic [DATA_W-1:0]    data_r;
  logic                 perr_r;
  logic [ERR_CNT_W-1:0] err_r;
  logic                 start;
  logic                 bad;

  assign start = bus.in_valid & bus.in_start;
  assign bad   = xacc ^ bus.in_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A start qualifier in any state opens a fresh frame, discarding a partial one.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (DATA_W == 1) ? PARITY : DATA;
    end else if (bus.in_valid) begin
      case (state)
        DATA:    if (cnt == LAST_IDX) state_next = PARITY;
        PARITY:  state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      xacc   <= 1'b0;
      ov_r   <= 1'b0;
      data_r <= '0;
      perr_r <= 1'b0;
      err_r  <= '0;
    end else begin
      ov_r <= 1'b0;
      if (start) begin
        shreg <= DATA_W'(bus.in_bit);
        cnt   <= CNT_W'(1);
        xacc  <= bus.in_bit;
      end else if (bus.in_valid) begin
        case (state)
          DATA: begin
            shreg <= (shreg << 1) | DATA_W'(bus.in_bit);
            cnt   <= cnt + CNT_W'(1);
            xacc  <= xacc ^ bus.in_bit;
          end
          PARITY: begin
            data_r <= shreg;
            perr_r <= bad;
            ov_r   <= 1'b1;
            if (bad && (err_r != '1)) err_r <= err_r + ERR_CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.out_valid  = ov_r;
    bus.out_data   = data_r;
    bus.parity_err = perr_r;
    bus.err_count  = err_r;
  end
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - scoreboard bench for parity_frame_checker.
module tb_parity_frame_checker;
  typedef struct packed {
    logic [2:0] d;
    logic       p;
    logic [7:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  exp_t q[$];

  parity_frame_checker_if #(.DATA_W(3), .ERR_CNT_W(8)) ifc ();
  parity_frame_checker #(.DATA_W(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic b);
    ifc.in_valid = v;
    ifc.in_start = s;
    ifc.in_bit   = b;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_start = 1'b0;
  endtask

  task automatic gaps(input int n);
    for (int g = 0; g < n; g++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("busy_gap", {31'b0, ifc.busy}, 32'd1);
    end
  endtask

  task automatic frame(input logic [2:0] d, input logic par, input logic exp_p, input int ng);
    exp_t e;
    cyc(1'b1, 1'b1, d[2]);
    gaps(ng);
    cyc(1'b1, 1'b0, d[1]);
    gaps(ng);
    cyc(1'b1, 1'b0, d[0]);
    gaps(ng);
    if (exp_p && exp_err < 255) exp_err++;
    e.d = d;
    e.p = exp_p;
    e.c = 8'(exp_err);
    q.push_back(e);
    cyc(1'b1, 1'b0, par);
  endtask

  // Monitor: every observed out_valid consumes one expected entry.
  always @(negedge clk) begin
    if (ifc.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data",   {29'b0, ifc.out_data},   {29'b0, e.d});
        chk("parity_err", {31'b0, ifc.parity_err}, {31'b0, e.p});
        chk("err_count",  {24'b0, ifc.err_count},  {24'b0, e.c});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_start = 1'b0;
    ifc.in_bit   = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, ifc.busy},      32'd0);
    chk("rst_err_count", {24'b0, ifc.err_count}, 32'd0);
    chk("rst_out_data",  {29'b0, ifc.out_data},  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    frame(3'b101, 1'b0, 1'b0, 0);
    frame(3'b011, 1'b1, 1'b1, 0);
    frame(3'b000, 1'b0, 1'b0, 0);
    frame(3'b001, 1'b1, 1'b0, 0);
    frame(3'b010, 1'b1, 1'b0, 0);
    frame(3'b011, 1'b0, 1'b0, 0);
    frame(3'b100, 1'b1, 1'b0, 0);
    frame(3'b101, 1'b0, 1'b0, 0);
    frame(3'b110, 1'b0, 1'b0, 0);
    frame(3'b111, 1'b1, 1'b0, 0);
    frame(3'b000, 1'b1, 1'b1, 0);
    frame(3'b001, 1'b0, 1'b1, 0);
    frame(3'b010, 1'b0, 1'b1, 0);
    frame(3'b011, 1'b1, 1'b1, 0);
    frame(3'b100, 1'b0, 1'b1, 0);
    frame(3'b101, 1'b1, 1'b1, 0);
    frame(3'b110, 1'b1, 1'b1, 0);
    frame(3'b111, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_count_9", {24'b0, ifc.err_count}, 32'd9);

    frame(3'b110, 1'b0, 1'b0, 2);
    cyc(1'b0, 1'b0, 1'b0);
    chk("busy_idle", {31'b0, ifc.busy}, 32'd0);

    // Abort after two bits; only the restarted frame completes.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    frame(3'b001, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",      {31'b0, ifc.busy},       32'd0);
    chk("mid_rst_out_valid", {31'b0, ifc.out_valid},  32'd0);
    chk("mid_rst_out_data",  {29'b0, ifc.out_data},   32'd0);
    chk("mid_rst_perr",      {31'b0, ifc.parity_err}, 32'd0);
    chk("mid_rst_err_count", {24'b0, ifc.err_count},  32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    exp_err = 0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_busy", {31'b0, ifc.busy}, 32'd0);

    for (int i = 0; i < 256; i++) frame(3'(i), ~(^3'(i)), 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_count_sat", {24'b0, ifc.err_count}, 32'd255);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
